run_length_pulse_detector: RTL and testbench

- Multi-channel, parametrised successor of the two-flop "first-high" Moore detector.
- Per channel: qualifies an input held at its active level for RUN_LEN consecutive clock edges, then emits a one-cycle Moore pulse.
- Optional auto-repeat while the input is held.
- Shared saturating event counter for the debug/status path.

---
 rtl/run_length_pulse_detector_pkg.sv | 10 +
 rtl/run_length_pulse_detector_if.sv | 12 +
 rtl/run_length_pulse_detector_channel.sv | 56 +++++
 rtl/run_length_pulse_detector.sv | 42 ++++
 tb/tb_run_length_pulse_detector.sv | 90 +++++++++
 5 files changed

// File: rtl/run_length_pulse_detector_pkg.sv
// run_length_pulse_detector_pkg: shared state encoding and counter sizing
package run_length_pulse_detector_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, COUNT = 2'd1, FIRE = 2'd2, HOLD = 2'd3} state_t;
  // one counter serves both the run length and the repeat period
  function automatic int ctr_w(int run_len, int rep);
    int m;
    m = run_len > rep ? run_len : rep;
    return $clog2(m < 2 ? 2 : m);
  endfunction
endpackage

// File: rtl/run_length_pulse_detector_if.sv
// run_length_pulse_detector_if: channel inputs, pulse outputs and status counter
interface run_length_pulse_detector_if #(parameter int CHANNELS = 4, parameter int CNT_W = 16);
  logic                en;
  logic                clr;
  logic [CHANNELS-1:0] pol;
  logic [CHANNELS-1:0] w;
  logic [CHANNELS-1:0] z;
  logic [CHANNELS-1:0] held;
  logic [CNT_W-1:0]    event_count;
  modport master(output en, clr, pol, w, input z, held, event_count);
  modport slave(input en, clr, pol, w, output z, held, event_count);
endinterface

// File: rtl/run_length_pulse_detector_channel.sv
// run_length_channel: one channel's qualify/fire/hold FSM with a shared run/repeat counter
module run_length_channel
  import run_length_pulse_detector_pkg::*;
#(
  parameter int RUN_LEN = 1,
  parameter int REPEAT  = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic act,
  output logic fire,
  output logic z,
  output logic held
);
  localparam int W = ctr_w(RUN_LEN, REPEAT);
  state_t state, nxt;
  logic [W-1:0] cnt, nxt_cnt;
  always_comb begin
    nxt = IDLE;
    nxt_cnt = '0;
    if (en && act)
      unique case (state)
        IDLE: begin
          nxt = RUN_LEN == 1 ? FIRE : COUNT;
          nxt_cnt = RUN_LEN == 1 ? '0 : W'(1);
        end
        COUNT: begin
          nxt = cnt == W'(RUN_LEN - 1) ? FIRE : COUNT;
          nxt_cnt = cnt + W'(1);
        end
        FIRE: begin
          nxt = HOLD;
          nxt_cnt = W'(1);
        end
        HOLD: begin
          nxt = REPEAT != 0 && cnt == W'(REPEAT - 1) ? FIRE : HOLD;
          nxt_cnt = cnt == '1 ? cnt : cnt + W'(1);
        end
      endcase
  end
  assign fire = nxt == FIRE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      z <= 1'b0;
      held <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= nxt_cnt;
      z <= nxt == FIRE;
      held <= nxt == FIRE || nxt == HOLD;
    end
  end
endmodule

// File: rtl/run_length_pulse_detector.sv
// run_length_pulse_detector: per-channel run-length pulse detectors plus saturating fire counter
module run_length_pulse_detector
  import run_length_pulse_detector_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int RUN_LEN  = 1,
  parameter int REPEAT   = 0,
  parameter int CNT_W    = 16
) (
  input logic clk,
  input logic rst_n,
  run_length_pulse_detector_if.slave bus
);
  localparam int SW = CNT_W + 6;
  logic [CHANNELS-1:0] fire, z, held;
  logic [CNT_W-1:0] cnt;
  logic [SW-1:0] pop, sum;
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    run_length_channel #(.RUN_LEN(RUN_LEN), .REPEAT(REPEAT)) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (bus.en),
      .act  (bus.w[i] == bus.pol[i]),
      .fire (fire[i]),
      .z    (z[i]),
      .held (held[i])
    );
  end
  always_comb begin
    pop = '0;
    for (int i = 0; i < CHANNELS; i++) pop = pop + SW'(fire[i]);
  end
  assign sum = SW'(cnt) + pop;
  // counter never wraps: clamp at all-ones
  always_ff @(posedge clk) begin
    if (!rst_n || bus.clr) cnt <= '0;
    else cnt <= sum > SW'({CNT_W{1'b1}}) ? '1 : sum[CNT_W-1:0];
  end
  assign bus.z = z;
  assign bus.held = held;
  assign bus.event_count = cnt;
endmodule

// File: tb/tb_run_length_pulse_detector.sv
// tb_run_length_pulse_detector: random stimulus on three configurations against a streak-based model
module tb_run_length_pulse_detector;
  logic clk = 1'b0;
  logic rst_n, en, clr;
  logic [3:0] pol, w;
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;

  run_length_pulse_detector_if #(.CHANNELS(4), .CNT_W(16)) b0 ();
  run_length_pulse_detector_if #(.CHANNELS(4), .CNT_W(4))  b1 ();
  run_length_pulse_detector_if #(.CHANNELS(4), .CNT_W(8))  b2 ();
  assign b0.en = en;  assign b0.clr = clr;  assign b0.pol = pol;  assign b0.w = w;
  assign b1.en = en;  assign b1.clr = clr;  assign b1.pol = pol;  assign b1.w = w;
  assign b2.en = en;  assign b2.clr = clr;  assign b2.pol = pol;  assign b2.w = w;

  run_length_pulse_detector #(.CHANNELS(4), .RUN_LEN(1), .REPEAT(0), .CNT_W(16)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  run_length_pulse_detector #(.CHANNELS(4), .RUN_LEN(3), .REPEAT(4), .CNT_W(4))  u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  run_length_pulse_detector #(.CHANNELS(4), .RUN_LEN(2), .REPEAT(2), .CNT_W(8))  u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  int run_len[3] = '{1, 3, 2};
  int period[3]  = '{0, 4, 2};
  int cnt_max[3] = '{65535, 15, 255};
  int streak[3][4];
  int exp_cnt[3];
  logic [3:0] exp_z[3], exp_held[3];

  task automatic check(string tag, int got, int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // a channel's output is fully determined by how many consecutive active, enabled samples it has seen
  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      int pop = 0;
      for (int c = 0; c < 4; c++) begin
        int s;
        streak[k][c] = (rst_n && en && (w[c] == pol[c])) ? streak[k][c] + 1 : 0;
        s = streak[k][c];
        exp_held[k][c] = s >= run_len[k];
        exp_z[k][c] = s >= run_len[k] &&
                      (period[k] == 0 ? s == run_len[k] : (s - run_len[k]) % period[k] == 0);
        pop += int'(exp_z[k][c]);
      end
      if (!rst_n || clr) exp_cnt[k] = 0;
      else exp_cnt[k] = exp_cnt[k] + pop > cnt_max[k] ? cnt_max[k] : exp_cnt[k] + pop;
    end
  endtask

  task automatic check_all(int cyc);
    logic [3:0] zq[3], hq[3];
    int cq[3];
    zq[0] = b0.z; zq[1] = b1.z; zq[2] = b2.z;
    hq[0] = b0.held; hq[1] = b1.held; hq[2] = b2.held;
    cq[0] = int'(b0.event_count); cq[1] = int'(b1.event_count); cq[2] = int'(b2.event_count);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("z[u%0d@%0d]", k, cyc), int'(zq[k]), int'(exp_z[k]));
      check($sformatf("held[u%0d@%0d]", k, cyc), int'(hq[k]), int'(exp_held[k]));
      check($sformatf("event_count[u%0d@%0d]", k, cyc), cq[k], exp_cnt[k]);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; pol = 4'b1111; w = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      exp_cnt[k] = 0;
      for (int c = 0; c < 4; c++) streak[k][c] = 0;
    end
    model_step();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      check_all(i);
      rst_n = i < 3 ? 1'b0 : ($urandom_range(0, 299) != 0);
      en = $urandom_range(0, 39) != 0;
      clr = $urandom_range(0, 79) == 0;
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range(0, 5) == 0) w[c] = ~w[c];
        if ($urandom_range(0, 59) == 0) pol[c] = ~pol[c];
      end
      model_step();
    end
    @(negedge clk);
    check_all(3000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
